// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the APB register file.
// Holds the bus FSM state encoding, the CTRL register layout and the index-width helper.
package apb_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RDATA = 2'd2
  } state_t;

  localparam int CTRL_IDX   = 0;
  localparam int REG_STRIDE = 4;
  localparam int START_BIT  = 0;

  function automatic int idx_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/apb_reg_word.sv
// A single data word register with a per-byte write enable.
// It is cleared by an asynchronous active-low reset.
module apb_reg_word #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [W/8-1:0] be,
  input  logic [W-1:0]   d,
  output logic [W-1:0]   q
);

  logic [W-1:0] mask;

  for (genvar gi = 0; gi < W/8; gi++) begin : g_mask
    assign mask[gi*8 +: 8] = {8{be[gi]}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (we)
      q <= (q & ~mask) | (d & mask);
  end

endmodule

// File: rtl/apb_regfile_ctrl.sv
// APB3 slave register file: zero-wait writes, one-wait reads, busy write lock-out, start pulse.
// The optional byte-strobe port is enabled by defining APB_PSTRB_EN.
module apb_regfile_ctrl
  import apb_regfile_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int NUM_REGS        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic [AMBA_WORD-1:0]          PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [AMBA_WORD/8-1:0]        PSTRB,
`endif
  input  logic                          busy_i,
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs_o,
  output logic                          start
);

  localparam int NB    = AMBA_WORD / 8;
  localparam int IDX_W = idx_width(NUM_REGS);
  localparam int LSB   = $clog2(REG_STRIDE);

  state_t             state;
  logic               rd_err;
  logic [NB-1:0]      strb;
  logic [3:0]         idx;
  logic               addr_err;
  logic               wr_access;
  logic               wr_err;
  logic               wr_ok;
  logic [AMBA_WORD-1:0] word_q [NUM_REGS];
  logic [AMBA_WORD-1:0] rd_word;

`ifdef APB_PSTRB_EN
  assign strb = PSTRB;
`else
  assign strb = '1;
`endif

  assign idx      = PADDR[LSB +: 4];
  assign addr_err = (int'(idx) >= NUM_REGS) || (PADDR[LSB-1:0] != '0) ||
                    (PADDR[AMBA_ADDR_WIDTH-1:LSB+4] != '0);

  assign wr_access = (state == SETUP) && PSEL && PENABLE && PWRITE;
  assign wr_err    = addr_err || busy_i;
  assign wr_ok     = wr_access && !wr_err;
  assign rd_word   = word_q[idx[IDX_W-1:0]];

  // Write completion is combinational in the access cycle; read completion comes from RDATA.
  assign PREADY  = wr_access || ((state == RDATA) && PSEL);
  assign PSLVERR = (wr_access && wr_err) || ((state == RDATA) && PSEL && rd_err);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    apb_reg_word #(.W(AMBA_WORD)) u_word (
      .clk (clk),
      .rst (rst),
      .we  (wr_ok && (int'(idx) == gi)),
      .be  (strb),
      .d   (PWDATA),
      .q   (word_q[gi])
    );
    assign regs_o[gi*AMBA_WORD +: AMBA_WORD] = word_q[gi];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      PRDATA <= '0;
      rd_err <= 1'b0;
      start  <= 1'b0;
    end else begin
      start <= wr_ok && (int'(idx) == CTRL_IDX) && PWDATA[START_BIT] && strb[START_BIT];
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE)
            state <= SETUP;
        end
        SETUP: begin
          if (!PSEL)
            state <= IDLE;
          else if (PENABLE) begin
            if (PWRITE)
              state <= IDLE;
            else begin
              state  <= RDATA;
              rd_err <= addr_err;
              PRDATA <= addr_err ? '0 : rd_word;
            end
          end
        end
        RDATA:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_ctrl.sv
// Table-driven bench for apb_regfile_ctrl with a response scoreboard and a register model.
// Byte-strobe vectors are added when APB_PSTRB_EN is defined.
module tb_apb_regfile_ctrl;

  localparam int W  = 32;
  localparam int AW = 20;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE  = 1'b0;
  logic [AW-1:0] PADDR   = '0;
  logic [W-1:0]  PWDATA  = '0;
  logic [W/8-1:0] PSTRB  = '1;
  logic          busy_i  = 1'b0;
  logic [W-1:0]  PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [N*W-1:0] regs_o;
  logic          start;

  apb_regfile_ctrl #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
`ifdef APB_PSTRB_EN
    .PSTRB   (PSTRB),
`endif
    .busy_i  (busy_i),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .regs_o  (regs_o),
    .start   (start)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [3:0]    strb;
    logic          busy;
    logic [W-1:0]  exp_rdata;
    logic          exp_err;
    logic          exp_start;
  } vec_t;

  typedef struct {
    logic         wr;
    logic [W-1:0] rdata;
    logic         err;
    int           lat;
  } exp_t;

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];
  vec_t tbl[$];
  logic [W-1:0] model [N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  task automatic check_regs();
    for (int i = 0; i < N; i++)
      check($sformatf("regs_o[%0d]", i), regs_o[i*W +: W], model[i]);
  endtask

  task automatic xfer(input vec_t v);
    exp_t e;
    exp_t got;
    int waits;
    e.wr = v.wr; e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.wr ? 0 : 1;
    sb.push_back(e);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = v.wr; PADDR = v.addr;
    PWDATA = v.wdata; PSTRB = v.strb; busy_i = v.busy;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!PREADY && waits < 5) begin
      check("pslverr_while_wait", PSLVERR, 1'b0);
      waits++;
      @(negedge clk);
    end
    got = sb.pop_front();
    check($sformatf("pready %s %0h", v.wr ? "wr" : "rd", v.addr), PREADY, 1'b1);
    check("latency", waits, got.lat);
    check("pslverr", PSLVERR, got.err);
    if (!got.wr) check("prdata", PRDATA, got.rdata);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; busy_i = 1'b0;
    if (v.wr && !v.exp_err) begin
      for (int b = 0; b < W/8; b++) begin
`ifdef APB_PSTRB_EN
        if (v.strb[b]) model[int'(v.addr[5:2])][b*8 +: 8] = v.wdata[b*8 +: 8];
`else
        model[int'(v.addr[5:2])][b*8 +: 8] = v.wdata[b*8 +: 8];
`endif
      end
    end
    @(negedge clk);
    check("start", start, v.exp_start);
    check_regs();
    @(negedge clk);
    check("start_one_cycle", start, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) model[i] = '0;
    //            wr    addr      wdata          strb  busy  rdata          err   start
    tbl.push_back('{1'b1, 20'h00000, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0,         1'b0, 1'b1});
    tbl.push_back('{1'b1, 20'h00008, 32'h0000_1234, 4'hF, 1'b0, 32'h0,         1'b0, 1'b0});
    tbl.push_back('{1'b0, 20'h00008, 32'h0,         4'hF, 1'b0, 32'h0000_1234, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 20'h00010, 32'h0,         4'hF, 1'b0, 32'h0,         1'b1, 1'b0});
    tbl.push_back('{1'b1, 20'h00006, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         1'b1, 1'b0});
    tbl.push_back('{1'b0, 20'h00000, 32'h0,         4'hF, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 20'h00000, 32'h0000_0001, 4'hF, 1'b1, 32'h0,         1'b1, 1'b0});
    tbl.push_back('{1'b0, 20'h00000, 32'h0,         4'hF, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 20'h00004, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         1'b0, 1'b0});
    tbl.push_back('{1'b0, 20'h00004, 32'h0,         4'hF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 20'h00000, 32'h0000_0002, 4'hF, 1'b0, 32'h0,         1'b0, 1'b0});
    tbl.push_back('{1'b0, 20'h00100, 32'h0,         4'hF, 1'b0, 32'h0,         1'b1, 1'b0});
    tbl.push_back('{1'b0, 20'h0000C, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0, 1'b0});
    tbl.push_back('{1'b1, 20'h0000C, 32'h0000_0001, 4'hF, 1'b0, 32'h0,         1'b0, 1'b0});
    tbl.push_back('{1'b0, 20'h00000, 32'h0,         4'hF, 1'b0, 32'h0000_0002, 1'b0, 1'b0});
`ifdef APB_PSTRB_EN
    tbl.push_back('{1'b1, 20'h00004, 32'h0000_0000, 4'h5, 1'b0, 32'h0,         1'b0, 1'b0});
    tbl.push_back('{1'b0, 20'h00004, 32'h0,         4'hF, 1'b0, 32'hFF00_FF00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 20'h00004, 32'h1234_5678, 4'h0, 1'b0, 32'h0,         1'b0, 1'b0});
    tbl.push_back('{1'b1, 20'h00000, 32'h0000_0101, 4'hE, 1'b0, 32'h0,         1'b0, 1'b0});
    tbl.push_back('{1'b0, 20'h00000, 32'h0,         4'hF, 1'b0, 32'h0000_0102, 1'b0, 1'b0});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pready", PREADY, 1'b0);
    check("reset_pslverr", PSLVERR, 1'b0);
    check("reset_prdata", PRDATA, '0);
    check("reset_start", start, 1'b0);
    check_regs();
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (tbl[i]) xfer(tbl[i]);

    // Abort a write by dropping PSEL in the access cycle
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h8; PWDATA = 32'h0000_0BAD;
    @(posedge clk); #1;
    PSEL = 1'b0;
    @(negedge clk);
    check("abort_wr_pready", PREADY, 1'b0);
    check("abort_wr_pslverr", PSLVERR, 1'b0);
    @(negedge clk);
    check_regs();

    // Abort a read during its wait state
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 20'h0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    check("abort_rd_wait_pready", PREADY, 1'b0);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    check("abort_rd_pready", PREADY, 1'b0);
    check("abort_rd_pslverr", PSLVERR, 1'b0);

    // Reset asserted in the access cycle of a write to reg0 with the start bit set
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h0; PWDATA = 32'h0000_0077;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) model[i] = '0;
    @(negedge clk);
    check("rstmid_pready", PREADY, 1'b0);
    check("rstmid_pslverr", PSLVERR, 1'b0);
    check("rstmid_prdata", PRDATA, '0);
    check("rstmid_start", start, 1'b0);
    check_regs();
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_start", start, 1'b0);
    check_regs();

    // Back-to-back after reset still works
    xfer('{1'b1, 20'h00008, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0});
    xfer('{1'b0, 20'h00008, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0});
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
